// File: rtl/mw_pkg.sv
// Shared definitions for the magnetron control stage: FSM states and pulse counter sizing.
package mw_pkg;

    typedef enum logic [2:0] {
        IDLE,
        COOK,
        PAUSE,
        PULSE_SET,
        PULSE_RST
    } mw_state_e;

    localparam int unsigned SYNC_STAGES_DEF = 2;
    localparam int unsigned PULSE_W_MAX     = 15;
    localparam int unsigned PULSE_CNT_W     = 4;

endpackage

// File: rtl/btn_sync_edge.sv
// Panel key conditioning: synchronizer, optional debouncer, rising-edge detector.
// Define MAGNETRON_DEBOUNCE_EN to insert a DEBOUNCE_CYC-sample debouncer after the synchronizer.
module btn_sync_edge
    import mw_pkg::*;
#(
    parameter int unsigned SYNC_STAGES  = SYNC_STAGES_DEF,
    parameter int unsigned DEBOUNCE_CYC = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    output logic rise
);

    if (SYNC_STAGES < 2 || DEBOUNCE_CYC < 1) begin : g_bad_param
        $error("btn_sync_edge: SYNC_STAGES must be >= 2 and DEBOUNCE_CYC >= 1");
    end

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   level;
    logic                   prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], btn_in};
        prev_d = level;
    end

`ifdef MAGNETRON_DEBOUNCE_EN
    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYC + 1);

    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            stable_q, stable_d;

    // Counter tracks consecutive samples that disagree with the accepted level.
    always_comb begin
        db_cnt_d = '0;
        stable_d = stable_q;
        if (sync_q[SYNC_STAGES-1] != stable_q) begin
            if (db_cnt_q == DB_W'(DEBOUNCE_CYC - 1)) begin
                stable_d = sync_q[SYNC_STAGES-1];
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt_q <= '0;
            stable_q <= 1'b0;
        end else begin
            db_cnt_q <= db_cnt_d;
            stable_q <= stable_d;
        end
    end

    assign level = stable_q;
`else
    assign level = sync_q[SYNC_STAGES-1];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rise = level & ~prev_q;

endmodule

// File: rtl/magnetron_ctrl.sv
// Magnetron latch control: cook/pause/idle FSM issuing exclusive set/reset pulses.
// MAGNETRON_DEBOUNCE_EN (see btn_sync_edge) adds key debouncing; door is never debounced.
module magnetron_ctrl
    import mw_pkg::*;
#(
    parameter int unsigned SYNC_STAGES  = SYNC_STAGES_DEF,
    parameter int unsigned PULSE_W      = 2,
    parameter int unsigned DEBOUNCE_CYC = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start_btn,
    input  logic stop_btn,
    input  logic door_closed,
    input  logic timer_zero,
    output logic mag_set,
    output logic mag_reset,
    output logic cooking,
    output logic paused,
    output logic done
);

    if (PULSE_W < 1 || PULSE_W > PULSE_W_MAX) begin : g_bad_param
        $error("magnetron_ctrl: PULSE_W must be within 1..15");
    end

    localparam logic [PULSE_CNT_W-1:0] PULSE_LAST = PULSE_CNT_W'(PULSE_W - 1);

    logic start_rise, stop_rise, door_ok;
    logic [SYNC_STAGES-1:0] door_sync_q, door_sync_d;

    btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYC(DEBOUNCE_CYC)) u_start (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_in (start_btn),
        .rise   (start_rise)
    );

    btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYC(DEBOUNCE_CYC)) u_stop (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_in (stop_btn),
        .rise   (stop_rise)
    );

    assign door_sync_d = {door_sync_q[SYNC_STAGES-2:0], door_closed};
    assign door_ok     = door_sync_q[SYNC_STAGES-1];

    mw_state_e              state_q, state_d;
    logic [PULSE_CNT_W-1:0] cnt_q, cnt_d;
    logic                   to_pause_q, to_pause_d;
    logic                   mag_set_q, mag_set_d;
    logic                   mag_reset_q, mag_reset_d;
    logic                   cooking_q, cooking_d;
    logic                   paused_q, paused_d;
    logic                   done_q, done_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        to_pause_d = to_pause_q;
        done_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!stop_rise && !timer_zero && start_rise && door_ok) begin
                    state_d = PULSE_SET;
                    cnt_d   = PULSE_LAST;
                end
            end
            COOK: begin
                if (!door_ok || stop_rise) begin
                    state_d    = PULSE_RST;
                    cnt_d      = PULSE_LAST;
                    to_pause_d = 1'b1;
                end else if (timer_zero) begin
                    state_d    = PULSE_RST;
                    cnt_d      = PULSE_LAST;
                    to_pause_d = 1'b0;
                    done_d     = 1'b1;
                end
            end
            PAUSE: begin
                // Latch is already reset here, so stop/expiry go straight to IDLE.
                if (stop_rise || timer_zero) begin
                    state_d = IDLE;
                end else if (start_rise && door_ok) begin
                    state_d = PULSE_SET;
                    cnt_d   = PULSE_LAST;
                end
            end
            PULSE_SET: begin
                if (!door_ok) begin
                    state_d    = PULSE_RST;
                    cnt_d      = PULSE_LAST;
                    to_pause_d = 1'b1;
                end else if (cnt_q == '0) begin
                    state_d = COOK;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            PULSE_RST: begin
                if (cnt_q == '0) begin
                    state_d = to_pause_q ? PAUSE : IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        mag_set_d   = (state_d == PULSE_SET);
        mag_reset_d = (state_d == PULSE_RST);
        cooking_d   = (state_d == COOK) || (state_d == PULSE_SET);
        paused_d    = (state_d == PAUSE) || ((state_d == PULSE_RST) && to_pause_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            door_sync_q <= '0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            to_pause_q  <= 1'b0;
            mag_set_q   <= 1'b0;
            mag_reset_q <= 1'b0;
            cooking_q   <= 1'b0;
            paused_q    <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            door_sync_q <= door_sync_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            to_pause_q  <= to_pause_d;
            mag_set_q   <= mag_set_d;
            mag_reset_q <= mag_reset_d;
            cooking_q   <= cooking_d;
            paused_q    <= paused_d;
            done_q      <= done_d;
        end
    end

    assign mag_set   = mag_set_q;
    assign mag_reset = mag_reset_q;
    assign cooking   = cooking_q;
    assign paused    = paused_q;
    assign done      = done_q;

endmodule

// File: tb/tb_magnetron_ctrl.sv
// Self-checking bench for magnetron_ctrl: directed scenarios plus random stimulus vs. a reference model.
// With MAGNETRON_DEBOUNCE_EN defined, runs the debounce press-length scenario and exclusivity checks.
module tb_magnetron_ctrl;

    localparam int unsigned S  = 2;
    localparam int unsigned W  = 2;
    localparam int unsigned DB = 8;

    localparam int M_IDLE  = 0;
    localparam int M_COOK  = 1;
    localparam int M_PAUSE = 2;
    localparam int K_NONE  = 0;
    localparam int K_SET   = 1;
    localparam int K_RST   = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start_btn = 1'b1;
    logic stop_btn = 1'b1;
    logic door_closed = 1'b1;
    logic timer_zero = 1'b1;
    logic mag_set, mag_reset, cooking, paused, done;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    magnetron_ctrl #(
        .SYNC_STAGES  (S),
        .PULSE_W      (W),
        .DEBOUNCE_CYC (DB)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_btn   (start_btn),
        .stop_btn    (stop_btn),
        .door_closed (door_closed),
        .timer_zero  (timer_zero),
        .mag_set     (mag_set),
        .mag_reset   (mag_reset),
        .cooking     (cooking),
        .paused      (paused),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: panel pins seen SYNC_STAGES edges late, operating mode plus an optional pulse in flight.
    bit st_h[S+1];
    bit sp_h[S+1];
    bit dr_h[S+1];
    int m_mode, m_kind, m_left, m_dest;
    bit m_done;

    task automatic model_reset();
        for (int i = 0; i <= S; i++) begin
            st_h[i] = 1'b0;
            sp_h[i] = 1'b0;
            dr_h[i] = 1'b0;
        end
        m_mode = M_IDLE;
        m_kind = K_NONE;
        m_left = 0;
        m_dest = M_IDLE;
        m_done = 1'b0;
    endtask

    task automatic begin_pulse(input int kind, input int dest);
        m_kind = kind;
        m_left = W;
        m_dest = dest;
    endtask

    task automatic model_step();
        bit start_ev, stop_ev, door, tz;
        start_ev = st_h[S-1] && !st_h[S];
        stop_ev  = sp_h[S-1] && !sp_h[S];
        door     = dr_h[S-1];
        tz       = timer_zero;
        m_done   = 1'b0;
        if (m_kind == K_SET && !door) begin
            begin_pulse(K_RST, M_PAUSE);
        end else if (m_kind != K_NONE) begin
            m_left--;
            if (m_left == 0) begin
                m_mode = m_dest;
                m_kind = K_NONE;
            end
        end else begin
            case (m_mode)
                M_IDLE: if (!stop_ev && !tz && start_ev && door) begin_pulse(K_SET, M_COOK);
                M_COOK: begin
                    if (!door || stop_ev) begin_pulse(K_RST, M_PAUSE);
                    else if (tz) begin
                        begin_pulse(K_RST, M_IDLE);
                        m_done = 1'b1;
                    end
                end
                default: begin
                    if (stop_ev || tz) m_mode = M_IDLE;
                    else if (start_ev && door) begin_pulse(K_SET, M_COOK);
                end
            endcase
        end
        for (int i = S; i > 0; i--) begin
            st_h[i] = st_h[i-1];
            sp_h[i] = sp_h[i-1];
            dr_h[i] = dr_h[i-1];
        end
        st_h[0] = start_btn;
        sp_h[0] = stop_btn;
        dr_h[0] = door_closed;
    endtask

    task automatic compare(input string tag);
        check({tag, "_excl"}, mag_set & mag_reset, 0);
`ifndef MAGNETRON_DEBOUNCE_EN
        check({tag, "_set"}, mag_set, m_kind == K_SET);
        check({tag, "_rst"}, mag_reset, m_kind == K_RST);
        check({tag, "_cook"}, cooking, (m_kind == K_SET) || (m_kind == K_NONE && m_mode == M_COOK));
        check({tag, "_pause"}, paused,
              (m_kind == K_NONE && m_mode == M_PAUSE) || (m_kind == K_RST && m_dest == M_PAUSE));
        check({tag, "_done"}, done, m_done);
`endif
    endtask

    task automatic cycle();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step();
        #1;
        compare("cyc");
    endtask

    int unsigned set_cnt, rst_cnt, done_cnt, first_set;

    task automatic run(input int unsigned n);
        set_cnt   = 0;
        rst_cnt   = 0;
        done_cnt  = 0;
        first_set = 0;
        for (int unsigned i = 1; i <= n; i++) begin
            cycle();
            if (mag_set) begin
                set_cnt++;
                if (first_set == 0) first_set = i;
            end
            if (mag_reset) rst_cnt++;
            if (done) done_cnt++;
        end
    endtask

    task automatic random_phase(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            if ($urandom_range(7) == 0)  start_btn   = ~start_btn;
            if ($urandom_range(24) == 0) stop_btn    = ~stop_btn;
            if ($urandom_range(39) == 0) door_closed = ~door_closed;
            if ($urandom_range(59) == 0) timer_zero  = ~timer_zero;
            if ((mag_set || mag_reset) && $urandom_range(29) == 0) begin
                rst_n = 1'b0;
                #1;
                model_reset();
                check("arst_set", mag_set, 0);
                check("arst_rst", mag_reset, 0);
                check("arst_cook", cooking, 0);
                check("arst_pause", paused, 0);
                cycle();
                rst_n = 1'b1;
            end
            cycle();
        end
    endtask

    initial begin
        model_reset();
        // Reset with every input high, then release with keys still held.
        run(3);
        check("t1_rst_set", set_cnt, 0);
        check("t1_rst_rst", rst_cnt, 0);
        rst_n = 1'b1;
        run(6);
        check("t1_idle_set", set_cnt, 0);
        check("t1_idle_rst", rst_cnt, 0);
        start_btn  = 1'b0;
        stop_btn   = 1'b0;
        timer_zero = 1'b0;
        run(3);

`ifndef MAGNETRON_DEBOUNCE_EN
        start_btn = 1'b1;
        run(5);
        check("t2_latency", first_set, S + 1);
        check("t2_width", set_cnt, W);
        check("t2_cooking", cooking, 1);
        run(10);
        check("t2_hold_noset", set_cnt, 0);
        start_btn = 1'b0;
        run(2);

        door_closed = 1'b0;
        run(8);
        check("t3_rst_width", rst_cnt, W);
        check("t3_paused", paused, 1);
        start_btn = 1'b1;
        run(6);
        check("t3_open_noset", set_cnt, 0);
        start_btn = 1'b0;
        run(2);
        door_closed = 1'b1;
        run(3);
        start_btn = 1'b1;
        run(8);
        check("t3_resume_set", set_cnt, W);
        check("t3_resume_cook", cooking, 1);
        start_btn = 1'b0;
        run(2);

        timer_zero = 1'b1;
        run(6);
        check("t4_rst_width", rst_cnt, W);
        check("t4_done_once", done_cnt, 1);
        check("t4_not_cook", cooking, 0);
        check("t4_not_pause", paused, 0);
        start_btn = 1'b1;
        run(8);
        check("t4_tz_noset", set_cnt, 0);
        start_btn  = 1'b0;
        timer_zero = 1'b0;
        run(3);

        start_btn = 1'b1;
        run(6);
        check("t5_cook", cooking, 1);
        start_btn   = 1'b0;
        run(2);
        stop_btn    = 1'b1;
        door_closed = 1'b0;
        run(8);
        check("t5_single_rst", rst_cnt, W);
        check("t5_paused", paused, 1);
        stop_btn = 1'b0;
        run(3);
        door_closed = 1'b1;
        run(3);
        stop_btn = 1'b1;
        run(6);
        check("t5_stop_norst", rst_cnt, 0);
        check("t5_stop_idle", paused, 0);
        stop_btn = 1'b0;
        run(2);

        random_phase(10000);
`else
        door_closed = 1'b1;
        run(4);
        start_btn = 1'b1;
        run(5);
        start_btn = 1'b0;
        run(40);
        check("db_short_noset", set_cnt, 0);
        start_btn = 1'b1;
        run(10);
        start_btn = 1'b0;
        run(40);
        check("db_long_set", set_cnt + rst_cnt, W);
        check("db_long_cook", cooking, 1);
        random_phase(3000);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
